// File: rtl/dcm_adv_lock_monitor.sv
// Period/lock monitor for the divided DCM clock: measures mon_clk periods in
// reference-clock cycles, declares lock after LOCK_COUNT stable matches, flags loss and stop.
module dcm_adv_lock_monitor #(
    parameter int CNT_W      = 16,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clock,
    input  logic             rst_reg,
    input  logic             mon_clk,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic             stopped
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
    localparam logic [MW-1:0]    MATCH_TGT = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        MEAS   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // Difference taken one bit wider than the operands so it can never underflow.
    function automatic logic within_tol(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] diff;
        if (a >= b) begin
            diff = {1'b0, a} - {1'b0, b};
        end else begin
            diff = {1'b0, b} - {1'b0, a};
        end
        return (diff <= TOL_V);
    endfunction

    state_t           state_r, state_s;
    logic [2:0]       sync_r;
    logic [CNT_W-1:0] cnt_r, cnt_s, prev_r, prev_s, period_r, period_s;
    logic [MW-1:0]    match_r, match_s, match_inc_s;
    logic             first_r, first_s;
    logic             pv_r, pv_s, locked_r, locked_s, lost_r, lost_s, stopped_r, stopped_s;
    logic             edge_s, sat_s, cmp_ok_s;

    assign edge_s      = sync_r[1] & ~sync_r[2];
    assign sat_s       = (cnt_r == CNT_MAX);
    assign cmp_ok_s    = within_tol(cnt_r, prev_r);
    assign match_inc_s = (match_r == MATCH_TGT) ? match_r : (match_r + MATCH_ONE);

    // State, datapath and registered outputs.
    always_ff @(posedge clock or negedge rst_reg) begin
        if (!rst_reg) begin
            sync_r    <= 3'b000;
            state_r   <= IDLE;
            cnt_r     <= '0;
            prev_r    <= '0;
            match_r   <= '0;
            first_r   <= 1'b0;
            period_r  <= '0;
            pv_r      <= 1'b0;
            locked_r  <= 1'b0;
            lost_r    <= 1'b0;
            stopped_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[1:0], mon_clk};
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            prev_r    <= prev_s;
            match_r   <= match_s;
            first_r   <= first_s;
            period_r  <= period_s;
            pv_r      <= pv_s;
            locked_r  <= locked_s;
            lost_r    <= lost_s;
            stopped_r <= stopped_s;
        end
    end

    // Next-state and measurement datapath; an edge always wins over saturation.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        prev_s  = prev_r;
        match_s = match_r;
        first_s = first_r;
        if (!enable) begin
            state_s = IDLE;
            cnt_s   = '0;
            match_s = '0;
            first_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = ARM;
                    cnt_s   = '0;
                    match_s = '0;
                end
                ARM: begin
                    if (edge_s) begin
                        state_s = MEAS;
                        cnt_s   = CNT_ONE;
                        first_s = 1'b1;
                    end else if (sat_s) begin
                        cnt_s = cnt_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                MEAS, LOCKED: begin
                    if (edge_s) begin
                        cnt_s   = CNT_ONE;
                        prev_s  = cnt_r;
                        first_s = 1'b0;
                        if (first_r) begin
                            match_s = match_r;
                        end else if (cmp_ok_s) begin
                            match_s = match_inc_s;
                            state_s = (match_inc_s == MATCH_TGT) ? LOCKED : MEAS;
                        end else begin
                            match_s = '0;
                            state_s = MEAS;
                        end
                    end else if (sat_s) begin
                        state_s = ARM;
                        match_s = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    match_s = '0;
                    first_s = 1'b0;
                end
            endcase
        end
    end

    // Output values to be registered alongside the state.
    always_comb begin
        period_s  = period_r;
        pv_s      = 1'b0;
        lost_s    = 1'b0;
        stopped_s = stopped_r;
        locked_s  = (state_s == LOCKED);
        if (!enable) begin
            stopped_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    stopped_s = 1'b0;
                end
                ARM: begin
                    if (edge_s) begin
                        stopped_s = 1'b0;
                    end else if (sat_s) begin
                        stopped_s = 1'b1;
                    end else begin
                        stopped_s = stopped_r;
                    end
                end
                MEAS, LOCKED: begin
                    if (edge_s) begin
                        period_s  = cnt_r;
                        pv_s      = 1'b1;
                        stopped_s = 1'b0;
                        lost_s    = (state_r == LOCKED) && (state_s == MEAS);
                    end else if (sat_s) begin
                        stopped_s = 1'b1;
                        lost_s    = (state_r == LOCKED);
                    end else begin
                        stopped_s = stopped_r;
                    end
                end
                default: begin
                    stopped_s = 1'b0;
                end
            endcase
        end
    end

    assign period       = period_r;
    assign period_valid = pv_r;
    assign locked       = locked_r;
    assign lost         = lost_r;
    assign stopped      = stopped_r;
endmodule

// File: tb/tb_dcm_adv_lock_monitor.sv
// Randomized bench for dcm_adv_lock_monitor against an event-level reference model
// built from integer gap counts and a run length of matching captures.
module tb_dcm_adv_lock_monitor;
    localparam int CNT_W_P  = 6;
    localparam int TOL_P    = 1;
    localparam int LOCK_P   = 4;
    localparam int CNT_MAX  = (1 << CNT_W_P) - 1;

    logic               clock = 1'b0;
    logic               rst_reg = 1'b0;
    logic               mon_clk = 1'b0;
    logic               enable = 1'b0;
    logic [CNT_W_P-1:0] period;
    logic               period_valid, locked, lost, stopped;

    int checks = 0;
    int errors = 0;
    int lost_seen = 0;

    // Reference model state
    bit m_s0, m_s1, m_s2;
    bit idle, armed;
    int gap, prev, run;
    int e_period;
    bit e_pv, e_locked, e_lost, e_stopped;

    dcm_adv_lock_monitor #(.CNT_W(CNT_W_P), .TOL(TOL_P), .LOCK_COUNT(LOCK_P)) dut (
        .clock(clock),
        .rst_reg(rst_reg),
        .mon_clk(mon_clk),
        .enable(enable),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .lost(lost),
        .stopped(stopped)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_s0 = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
        idle = 1'b1; armed = 1'b0;
        gap = 0; prev = -1; run = 0;
        e_period = 0; e_pv = 1'b0; e_locked = 1'b0; e_lost = 1'b0; e_stopped = 1'b0;
    endtask

    task automatic model_step(input bit edge_m, input bit en);
        int gap_at;
        int diff;
        e_pv   = 1'b0;
        e_lost = 1'b0;
        if (!en) begin
            idle = 1'b1; armed = 1'b0; gap = 0; prev = -1; run = 0;
            e_locked = 1'b0; e_stopped = 1'b0;
        end else if (idle) begin
            idle = 1'b0;
            gap  = 0;
        end else if (edge_m) begin
            gap_at    = gap;
            gap       = 1;
            e_stopped = 1'b0;
            if (!armed) begin
                armed = 1'b1;
            end else begin
                e_period = gap_at;
                e_pv     = 1'b1;
                if (prev >= 0) begin
                    diff = (gap_at > prev) ? gap_at - prev : prev - gap_at;
                    if (diff <= TOL_P) begin
                        run++;
                    end else begin
                        e_lost = e_locked;
                        run    = 0;
                    end
                end
                prev     = gap_at;
                e_locked = (run >= LOCK_P);
            end
        end else if (gap == CNT_MAX) begin
            e_stopped = 1'b1;
            e_lost    = e_locked;
            e_locked  = 1'b0;
            run = 0; armed = 1'b0; prev = -1;
        end else begin
            gap++;
        end
    endtask

    // One reference-clock cycle: advance the model with pre-edge inputs, then compare.
    task automatic tick();
        bit edge_m;
        @(posedge clock);
        if (!rst_reg) begin
            model_reset();
        end else begin
            edge_m = m_s1 & ~m_s2;
            model_step(edge_m, enable);
            m_s2 = m_s1; m_s1 = m_s0; m_s0 = mon_clk;
        end
        #1;
        if (lost) lost_seen++;
        check_value("period", int'(period), e_period);
        check_value("period_valid", int'(period_valid), int'(e_pv));
        check_value("locked", int'(locked), int'(e_locked));
        check_value("lost", int'(lost), int'(e_lost));
        check_value("stopped", int'(stopped), int'(e_stopped));
    endtask

    task automatic drive_period(input int per, input int n, input int jitter);
        int p, hi;
        for (int i = 0; i < n; i++) begin
            p  = per + ((jitter > 0) ? int'($urandom_range(0, jitter)) : 0);
            hi = p / 2;
            mon_clk = 1'b1;
            repeat (hi) tick();
            mon_clk = 1'b0;
            repeat (p - hi) tick();
        end
    endtask

    task automatic hold_low(input int n);
        mon_clk = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int mode;
        model_reset();
        #1;
        check_value("reset_locked", int'(locked), 0);
        check_value("reset_period", int'(period), 0);
        check_value("reset_stopped", int'(stopped), 0);
        repeat (2) tick();
        rst_reg = 1'b1;
        enable  = 1'b1;

        // Steady 10-cycle clock locks on the 6th edge.
        drive_period(10, 8, 0);
        check_value("steady_lock", int'(locked), 1);
        check_value("steady_period", int'(period), 10);

        // 10 -> 20 while locked: one loss, then relock.
        lost_seen = 0;
        drive_period(20, 7, 0);
        check_value("change_lost_count", lost_seen, 1);
        check_value("change_relock", int'(locked), 1);

        // Tolerance boundary: 10/11 locks, 10/12 never does.
        for (int i = 0; i < 6; i++) begin
            drive_period(10, 1, 0);
            drive_period(11, 1, 0);
        end
        check_value("tol_in_lock", int'(locked), 1);
        for (int i = 0; i < 6; i++) begin
            drive_period(10, 1, 0);
            drive_period(12, 1, 0);
        end
        check_value("tol_out_nolock", int'(locked), 0);

        // Stop and restart.
        drive_period(12, 8, 0);
        hold_low(80);
        check_value("stop_flag", int'(stopped), 1);
        check_value("stop_unlocked", int'(locked), 0);
        drive_period(12, 9, 0);
        check_value("stop_relock", int'(locked), 1);
        check_value("stop_cleared", int'(stopped), 0);

        // Enable drop while locked, then re-enable.
        enable = 1'b0;
        drive_period(12, 1, 0);
        check_value("disable_unlocked", int'(locked), 0);
        enable = 1'b1;
        drive_period(12, 9, 0);
        check_value("reenable_lock", int'(locked), 1);

        // Asynchronous reset mid-lock.
        rst_reg = 1'b0;
        #1;
        check_value("arst_locked", int'(locked), 0);
        check_value("arst_period", int'(period), 0);
        check_value("arst_pv", int'(period_valid), 0);
        mon_clk = 1'b0;
        repeat (2) tick();
        #2;
        rst_reg = 1'b1;
        drive_period(12, 9, 0);
        check_value("arst_relock", int'(locked), 1);

        // Randomized mix of periods, jitter, stops and enable drops.
        for (int r = 0; r < 40; r++) begin
            mode = int'($urandom_range(0, 7));
            if (mode == 0) begin
                hold_low(int'($urandom_range(60, 80)));
            end else if (mode == 1) begin
                enable = 1'b0;
                repeat (int'($urandom_range(1, 5))) tick();
                enable = 1'b1;
            end else begin
                drive_period(int'($urandom_range(4, 30)), int'($urandom_range(2, 9)),
                             int'($urandom_range(0, 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
